// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Scans one hex-to-7-segment decoder across NUM_DIGITS
//               common-anode digits, with an all-off guard slot after each
//               digit. Optional macro SEVSEG_LEADING_ZERO_BLANK_EN adds
//               leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [DIG_W-1:0]        digit, digit_nxt;
    logic [CNT_W-1:0]        count, count_nxt;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
    logic [4*NUM_DIGITS-1:0] staged, staged_nxt;
    logic                    pending, pending_nxt;
    logic                    wrap;
    logic                    lz_dark;
    logic [NUM_DIGITS-1:0]   anode_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic [3:0]              nibble;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_7_seg(input logic [3:0] hex);
        case (hex)
            4'h0: hex_7_seg = 7'h40;
            4'h1: hex_7_seg = 7'h79;
            4'h2: hex_7_seg = 7'h24;
            4'h3: hex_7_seg = 7'h30;
            4'h4: hex_7_seg = 7'h19;
            4'h5: hex_7_seg = 7'h12;
            4'h6: hex_7_seg = 7'h02;
            4'h7: hex_7_seg = 7'h78;
            4'h8: hex_7_seg = 7'h00;
            4'h9: hex_7_seg = 7'h10;
            4'hA: hex_7_seg = 7'h08;
            4'hB: hex_7_seg = 7'h03;
            4'hC: hex_7_seg = 7'h46;
            4'hD: hex_7_seg = 7'h21;
            4'hE: hex_7_seg = 7'h06;
            default: hex_7_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_nxt   = state;
        digit_nxt   = digit;
        count_nxt   = count + CNT_W'(1);
        shadow_nxt  = shadow;
        staged_nxt  = staged;
        pending_nxt = pending;
        wrap        = 1'b0;

        case (state)
            IDLE: begin
                count_nxt = '0;
                digit_nxt = '0;
                if (enable) state_nxt = DWELL;
            end
            DWELL: begin
                if (count == DWELL_LAST) begin
                    state_nxt = GUARD;
                    count_nxt = '0;
                end
            end
            GUARD: begin
                if (count == GUARD_LAST) begin
                    state_nxt = DWELL;
                    count_nxt = '0;
                    if (digit == DIGIT_LAST) begin
                        digit_nxt = '0;
                        wrap      = 1'b1;
                    end else begin
                        digit_nxt = digit + DIG_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!enable) begin
            state_nxt = IDLE;
            digit_nxt = '0;
            count_nxt = '0;
            wrap      = 1'b0;
        end

        // Shadow only changes while idle or at the frame wrap, so a frame never tears
        if (state == IDLE) begin
            if (load) begin
                shadow_nxt  = value;
                pending_nxt = 1'b0;
            end
        end else if (wrap) begin
            if (load) begin
                shadow_nxt  = value;
                pending_nxt = 1'b0;
            end else if (pending) begin
                shadow_nxt  = staged;
                pending_nxt = 1'b0;
            end
        end else if (load) begin
            staged_nxt  = value;
            pending_nxt = 1'b1;
        end
    end

    // Outputs are computed from the next state so all pins move on one edge
    always_comb begin
        nibble = shadow_nxt[{digit_nxt, 2'b00} +: 4];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        lz_dark = (digit_nxt != '0) && ((shadow_nxt >> {digit_nxt, 2'b00}) == '0);
`else
        lz_dark = 1'b0;
`endif
        anode_nxt = '1;
        seg_nxt   = SEG_OFF;
        dp_nxt    = 1'b1;
        if (state_nxt == DWELL && !blank_mask[digit_nxt]) begin
            anode_nxt[digit_nxt] = 1'b0;
            dp_nxt               = ~dp_mask[digit_nxt];
            seg_nxt              = lz_dark ? SEG_OFF : hex_7_seg(nibble);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            digit      <= '0;
            count      <= '0;
            shadow     <= '0;
            staged     <= '0;
            pending    <= 1'b0;
            anode_n    <= '1;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            digit      <= digit_nxt;
            count      <= count_nxt;
            shadow     <= shadow_nxt;
            staged     <= staged_nxt;
            pending    <= pending_nxt;
            anode_n    <= anode_nxt;
            seg_n      <= seg_nxt;
            dp_n       <= dp_nxt;
            frame_done <= wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_ctrl
// Description : Directed bench for seven_seg_scan_ctrl (4 digits, dwell 4,
//               guard 2) with a frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int G     = 2;
    localparam int SLOT  = D + G;
    localparam int FRAME = N * SLOT;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [4*N-1:0] value;
    logic          load;
    logic [N-1:0]  dp_mask;
    logic [N-1:0]  blank_mask;
    logic [N-1:0]  anode_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_on = 1'b0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(D),
        .GUARD_CYCLES(G)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .enable    (enable),
        .value     (value),
        .load      (load),
        .dp_mask   (dp_mask),
        .blank_mask(blank_mask),
        .anode_n   (anode_n),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: position in the frame is plain cycle arithmetic
    logic [4*N-1:0] m_shadow, m_staged;
    bit             m_pending, m_running, m_wrap, m_dark;
    int             m_t, m_pos, m_d;
    logic [N-1:0]   e_anode;
    logic [6:0]     e_seg;
    logic           e_dp, e_fd;

    always @(posedge clk) begin
        if (reset) begin
            m_shadow = '0; m_staged = '0; m_pending = 0; m_running = 0; m_t = 0;
            e_anode = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            m_wrap = m_running && enable && ((m_t + 1) % FRAME == 0);
            if (!m_running) begin
                if (load) begin m_shadow = value; m_pending = 0; end
            end else if (m_wrap) begin
                if (load) begin m_shadow = value; m_pending = 0; end
                else if (m_pending) begin m_shadow = m_staged; m_pending = 0; end
            end else if (load) begin
                m_staged = value; m_pending = 1;
            end
            if (!enable) begin m_running = 0; m_t = 0; end
            else if (!m_running) begin m_running = 1; m_t = 0; end
            else m_t = m_t + 1;
            e_fd = m_wrap;
            e_anode = '1; e_seg = 7'h7F; e_dp = 1'b1;
            if (m_running) begin
                m_pos = m_t % FRAME;
                m_d   = m_pos / SLOT;
                m_dark = 0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
                m_dark = (m_d > 0) && (int'(m_shadow) / (1 << (4 * m_d)) == 0);
`endif
                if ((m_pos % SLOT) < D && !blank_mask[m_d]) begin
                    e_anode[m_d] = 1'b0;
                    e_dp  = !dp_mask[m_d];
                    e_seg = m_dark ? 7'h7F : SEG_TAB[m_shadow[4*m_d +: 4]];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            chk("model_anode", {28'd0, anode_n}, {28'd0, e_anode});
            chk("model_seg", {25'd0, seg_n}, {25'd0, e_seg});
            chk("model_dp", {31'd0, dp_n}, {31'd0, e_dp});
            chk("model_fd", {31'd0, frame_done}, {31'd0, e_fd});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd(output int at_cycle);
        bit found = 0;
        at_cycle = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (!found) begin
                @(negedge clk);
                at_cycle++;
                if (frame_done === 1'b1) found = 1;
            end
        end
        chk("frame_done_timeout", {31'd0, found}, 32'd1);
    endtask

    task automatic lit(input string name, input logic [N-1:0] an, input logic [6:0] sg);
        chk({name, "_anode"}, {28'd0, anode_n}, {28'd0, an});
        chk({name, "_seg"}, {25'd0, seg_n}, {25'd0, sg});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, dp_low, an2_low;
        reset = 1; enable = 0; load = 0; value = '0; dp_mask = '0; blank_mask = '0;
        step(3);
        check_on = 1;
        lit("reset", 4'hF, 7'h7F);
        chk("reset_dp", {31'd0, dp_n}, 32'd1);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);

        reset = 0; value = 16'h1234; load = 1; enable = 1;
        step(1); load = 0;
        lit("d0_first", 4'b1110, 7'h19);
        step(3); lit("d0_last", 4'b1110, 7'h19);
        step(1); lit("guard0", 4'hF, 7'h7F);
        step(2); lit("d1_first", 4'b1101, 7'h30);

        wait_fd(c1);
        wait_fd(c2);
        chk("frame_period", c2, FRAME);

        step(6); value = 16'hABCD; load = 1;
        step(1); load = 0;
        step(5); lit("old_d2", 4'b1011, 7'h24);
        step(6); lit("old_d3", 4'b0111, 7'h79);
        step(6); lit("new_d0", 4'b1110, 7'h21);
        chk("wrap_fd", {31'd0, frame_done}, 32'd1);
        step(6); lit("new_d1", 4'b1101, 7'h46);

        blank_mask = 4'b0100; dp_mask = 4'b0001;
        wait_fd(c1);
        dp_low = 0; an2_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1);
            if (dp_n == 1'b0) dp_low++;
            if (anode_n[2] == 1'b0) an2_low++;
        end
        chk("blank_period_fd", {31'd0, frame_done}, 32'd1);
        chk("dp_low_count", dp_low, 4);
        chk("anode2_never_low", an2_low, 0);

        blank_mask = '0; dp_mask = '0; value = 16'h1111; load = 1;
        step(1); value = 16'h5678;
        step(1); load = 0;
        step(16); lit("pend_old_d3", 4'b0111, 7'h08);
        step(6); lit("latest_wins", 4'b1110, 7'h00);

        step(23); value = 16'h9ABC; load = 1;
        step(1); load = 0;
        lit("load_at_wrap", 4'b1110, 7'h46);

        step(13); lit("pre_disable_d2", 4'b1011, 7'h08);
        enable = 0;
        step(1); lit("disabled", 4'hF, 7'h7F);
        chk("disabled_dp", {31'd0, dp_n}, 32'd1);
        step(2); lit("still_idle", 4'hF, 7'h7F);
        enable = 1;
        step(1); lit("restart_d0", 4'b1110, 7'h46);

        step(7); reset = 1;
        step(1); lit("mid_reset", 4'hF, 7'h7F);
        reset = 0;
        step(1); lit("post_reset_zero", 4'b1110, 7'h40);

        enable = 0;
        step(1); value = 16'h0050; load = 1; enable = 1;
        step(1); load = 0;
        lit("lz_d0", 4'b1110, 7'h40);
        step(6); lit("lz_d1", 4'b1101, 7'h12);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        step(6); lit("lz_d2", 4'b1011, 7'h7F);
        step(6); lit("lz_d3", 4'b0111, 7'h7F);
`else
        step(6); lit("lz_d2", 4'b1011, 7'h40);
        step(6); lit("lz_d3", 4'b0111, 7'h40);
`endif
        enable = 0;
        step(1); value = 16'h0000; load = 1; enable = 1;
        step(1); load = 0;
        lit("zero_d0", 4'b1110, 7'h40);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        step(6); lit("zero_d1", 4'b1101, 7'h7F);
`else
        step(6); lit("zero_d1", 4'b1101, 7'h40);
`endif
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
